// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU element-wise controller:
// default geometry, opcode encodings and the FSM state type.
package mpu_pkg;

    localparam int unsigned ELEM_W_DEF = 8;
    localparam int unsigned N_DIM_DEF  = 5;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_NEG  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mpu_row_alu.sv
// Combinational row ALU: N_DIM independent lanes of ELEM_W bits, each
// wrapping modulo 2^ELEM_W with no carry between lanes.
module mpu_row_alu
    import mpu_pkg::*;
#(
    parameter int unsigned ELEM_W = ELEM_W_DEF,
    parameter int unsigned N_DIM  = N_DIM_DEF
) (
    input  logic [ELEM_W*N_DIM-1:0] row_a,
    input  logic [ELEM_W*N_DIM-1:0] row_b,
    input  logic [1:0]              op,
    output logic [ELEM_W*N_DIM-1:0] row_r
);

    // Per-lane add / subtract / negate; reserved opcode yields zero.
    always_comb begin
        row_r = '0;
        for (int unsigned i = 0; i < N_DIM; i++) begin
            case (op)
                OP_ADD:  row_r[ELEM_W*i +: ELEM_W] = row_a[ELEM_W*i +: ELEM_W] + row_b[ELEM_W*i +: ELEM_W];
                OP_SUB:  row_r[ELEM_W*i +: ELEM_W] = row_a[ELEM_W*i +: ELEM_W] - row_b[ELEM_W*i +: ELEM_W];
                OP_NEG:  row_r[ELEM_W*i +: ELEM_W] = {ELEM_W{1'b0}} - row_a[ELEM_W*i +: ELEM_W];
                default: row_r[ELEM_W*i +: ELEM_W] = '0;
            endcase
        end
    end

endmodule

// File: rtl/mpu_elemwise_ctrl.sv
// Element-wise matrix controller: captures two N_DIM x N_DIM operands,
// computes one row per cycle through mpu_row_alu, then holds the result
// until the consumer takes it.
module mpu_elemwise_ctrl
    import mpu_pkg::*;
#(
    parameter int unsigned ELEM_W = ELEM_W_DEF,
    parameter int unsigned N_DIM  = N_DIM_DEF
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             cmd_valid,
    output logic                             cmd_ready,
    input  logic [1:0]                       cmd_op,
    input  logic [ELEM_W*N_DIM*N_DIM-1:0]    matrix_a,
    input  logic [ELEM_W*N_DIM*N_DIM-1:0]    matrix_b,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ELEM_W*N_DIM*N_DIM-1:0]    result,
    output logic                             rsp_error,
    output logic                             busy
);

    localparam int unsigned ROW_W = ELEM_W * N_DIM;
    localparam int unsigned MAT_W = ROW_W * N_DIM;
    localparam int unsigned CNT_W = (N_DIM > 1) ? $clog2(N_DIM) : 1;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   row_q;
    logic [MAT_W-1:0]   a_q;
    logic [MAT_W-1:0]   b_q;
    logic [MAT_W-1:0]   res_q;
    logic [1:0]         op_q;
    logic               err_q;
    logic               accept;
    logic               last_row;
    logic [ROW_W-1:0]   alu_row;

    assign accept   = cmd_valid & cmd_ready;
    assign last_row = (row_q == CNT_W'(N_DIM - 1));

    mpu_row_alu #(
        .ELEM_W (ELEM_W),
        .N_DIM  (N_DIM)
    ) u_row_alu (
        .row_a (a_q[ROW_W*row_q +: ROW_W]),
        .row_b (b_q[ROW_W*row_q +: ROW_W]),
        .op    (op_q),
        .row_r (alu_row)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_d = (cmd_op == OP_RSVD) ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_row) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Operand capture, row counter and row-by-row result accumulation.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            row_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
        end else if (accept) begin
            a_q   <= matrix_a;
            b_q   <= matrix_b;
            op_q  <= cmd_op;
            row_q <= '0;
            res_q <= '0;
            err_q <= (cmd_op == OP_RSVD);
        end else if (state_q == RUN) begin
            res_q[ROW_W*row_q +: ROW_W] <= alu_row;
            row_q <= last_row ? '0 : row_q + CNT_W'(1);
        end
    end

    assign result    = res_q;
    assign rsp_error = err_q & (state_q == DONE);

endmodule

// File: tb/tb_mpu_elemwise_ctrl.sv
// Directed self-checking bench for mpu_elemwise_ctrl at default geometry.
module tb_mpu_elemwise_ctrl;

    localparam int unsigned EW = 8;
    localparam int unsigned ND = 5;
    localparam int unsigned NE = ND * ND;
    localparam int unsigned MW = EW * NE;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [MW-1:0] matrix_a;
    logic [MW-1:0] matrix_b;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [MW-1:0] result;
    logic          rsp_error;
    logic          busy;

    int unsigned n_total;
    int unsigned n_bad;

    logic [MW-1:0] ma;
    logic [MW-1:0] mb;
    logic [MW-1:0] exp_sub;
    logic [MW-1:0] exp_add;
    logic [MW-1:0] exp_neg;
    logic [MW-1:0] exp_part;
    logic [MW-1:0] snap;
    logic          seen;

    mpu_elemwise_ctrl #(
        .ELEM_W (EW),
        .N_DIM  (ND)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .result    (result),
        .rsp_error (rsp_error),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [MW-1:0] got, input logic [MW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic tick(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [MW-1:0] a, input logic [MW-1:0] b);
        check_val("ready_before_cmd", MW'(cmd_ready), MW'(1));
        cmd_op    = op;
        matrix_a  = a;
        matrix_b  = b;
        cmd_valid = 1'b1;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        tick(1);
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_total   = 0;
        n_bad     = 0;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        matrix_a  = '0;
        matrix_b  = '0;
        rsp_ready = 1'b0;

        for (int e = 0; e < int'(NE); e++) begin
            ma[EW*e +: EW]       = 8'(e + 1);
            mb[EW*e +: EW]       = 8'(25 - e);
            exp_sub[EW*e +: EW]  = 8'((e + 1) - (25 - e));
            exp_add[EW*e +: EW]  = 8'd26;
            exp_neg[EW*e +: EW]  = 8'(256 - (e + 1));
            exp_part[EW*e +: EW] = (e < 2 * int'(ND)) ? 8'd26 : 8'd0;
        end

        tick(2);
        check_val("rst_cmd_ready", MW'(cmd_ready), MW'(1));
        check_val("rst_busy",      MW'(busy),      MW'(0));
        check_val("rst_rsp_valid", MW'(rsp_valid), MW'(0));
        check_val("rst_rsp_error", MW'(rsp_error), MW'(0));
        check_val("rst_result",    result,         '0);
        reset = 1'b0;
        tick(1);

        // SUB, latency and spot values, then backpressure in DONE
        issue(2'b01, ma, mb);
        check_val("sub_busy", MW'(busy), MW'(1));
        tick(ND - 1);
        check_val("sub_lat_early", MW'(rsp_valid), MW'(0));
        tick(1);
        check_val("sub_valid", MW'(rsp_valid), MW'(1));
        check_val("sub_error", MW'(rsp_error), MW'(0));
        check_val("sub_e0",  MW'(result[0 +: 8]),        MW'(232));
        check_val("sub_e12", MW'(result[EW*12 +: 8]),    MW'(0));
        check_val("sub_e24", MW'(result[EW*24 +: 8]),    MW'(24));
        check_val("sub_all", result, exp_sub);
        for (int k = 0; k < 3; k++) begin
            tick(1);
            check_val("bp_result",    result,           exp_sub);
            check_val("bp_rsp_valid", MW'(rsp_valid),   MW'(1));
            check_val("bp_cmd_ready", MW'(cmd_ready),   MW'(0));
        end
        consume();
        check_val("post_rsp_valid", MW'(rsp_valid), MW'(0));
        check_val("post_cmd_ready", MW'(cmd_ready), MW'(1));
        check_val("post_busy",      MW'(busy),      MW'(0));
        check_val("idle_hold",      result,         exp_sub);
        tick(1);

        // ADD on the same operands
        issue(2'b00, ma, mb);
        tick(ND);
        check_val("add_valid", MW'(rsp_valid), MW'(1));
        check_val("add_all",   result,         exp_add);
        consume();
        tick(1);

        // NEG ignores B
        issue(2'b10, ma, {NE{8'h5A}});
        tick(ND);
        check_val("neg_e0",  MW'(result[0 +: 8]), MW'(255));
        check_val("neg_all", result, exp_neg);
        consume();
        tick(1);

        // Reserved opcode
        issue(2'b11, ma, mb);
        check_val("rsvd_valid",  MW'(rsp_valid), MW'(1));
        check_val("rsvd_error",  MW'(rsp_error), MW'(1));
        check_val("rsvd_result", result,         '0);
        consume();
        check_val("rsvd_error_clr", MW'(rsp_error), MW'(0));
        tick(1);

        // Operand inputs change after acceptance
        issue(2'b01, ma, mb);
        matrix_a = '1;
        matrix_b = '0;
        cmd_op   = 2'b00;
        tick(ND);
        check_val("chg_valid",  MW'(rsp_valid), MW'(1));
        check_val("chg_result", result,         exp_sub);
        consume();
        tick(1);

        // Reset while in RUN at row 2
        issue(2'b00, ma, mb);
        tick(2);
        check_val("part_result", result, exp_part);
        reset = 1'b1;
        #1;
        check_val("mid_rst_rsp_valid", MW'(rsp_valid), MW'(0));
        check_val("mid_rst_busy",      MW'(busy),      MW'(0));
        check_val("mid_rst_cmd_ready", MW'(cmd_ready), MW'(1));
        check_val("mid_rst_error",     MW'(rsp_error), MW'(0));
        check_val("mid_rst_result",    result,         '0);
        #3;
        reset = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick(1);
            if (rsp_valid) seen = 1'b1;
        end
        check_val("no_rsp_after_rst", MW'(seen), MW'(0));
        issue(2'b00, ma, mb);
        tick(ND);
        check_val("after_rst_valid",  MW'(rsp_valid), MW'(1));
        check_val("after_rst_result", result,         exp_add);
        snap = result;
        consume();
        check_val("after_rst_idle_hold", result, snap);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mpu_elemwise_ctrl.md
MPU_ELEMWISE_CTRL -- requirements
Module: mpu_elemwise_ctrl

Interface
REQ-001 SHALL have parameter ELEM_W, default 8, meaning element width in bits.
REQ-002 SHALL have parameter N_DIM, default 5, meaning matrix dimension (N_DIM x N_DIM elements, N_DIM lanes per row).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_ready  output  1  controller accepts a command this cycle.
REQ-007 SHALL have port cmd_op  input  2  operation: 00 ADD (A+B), 01 SUB (A-B), 10 NEG (0-A), 11 reserved.
REQ-008 SHALL have port matrix_a  input  ELEM_W*N_DIM*N_DIM  operand A, flattened.
REQ-009 SHALL have port matrix_b  input  ELEM_W*N_DIM*N_DIM  operand B, flattened.
REQ-010 SHALL have port rsp_valid  output  1  result available.
REQ-011 SHALL have port rsp_ready  input  1  consumer takes result.
REQ-012 SHALL have port result  output  ELEM_W*N_DIM*N_DIM  result matrix, flattened.
REQ-013 SHALL have port rsp_error  output  1  qualifies rsp_valid; high for a reserved opcode.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL place element e (e = N_DIM*row + col) at bits [ELEM_W*e +: ELEM_W] in matrix_a, matrix_b and result; row r = elements N_DIM*r .. N_DIM*r+N_DIM-1.
REQ-016 SHALL implement FSM states IDLE, RUN, DONE; cmd_ready = 1 only in IDLE; rsp_valid = 1 only in DONE.
REQ-017 SHALL, on cmd_valid & cmd_ready, capture matrix_a, matrix_b and cmd_op into internal registers, clear row counter to 0, clear result to 0 and go to RUN (or to DONE if cmd_op = 11).
REQ-018 SHALL ignore changes on matrix_a, matrix_b and cmd_op after acceptance.
REQ-019 SHALL in RUN compute one row per cycle (N_DIM lanes in parallel) from captured operands, write it into result row counter, increment the counter, and go to DONE after row N_DIM-1.
REQ-020 SHALL compute each lane modulo 2^ELEM_W (unsigned wrap, no saturation, no carry between lanes).
REQ-021 SHALL assert rsp_valid exactly N_DIM cycles after the accepting edge for a legal opcode (5 cycles at defaults), and 1 cycle after for opcode 11.
REQ-022 SHALL for opcode 11 hold result = 0 and rsp_error = 1 while rsp_valid; rsp_error = 0 otherwise.
REQ-023 SHALL hold result, rsp_error and rsp_valid stable in DONE until rsp_ready = 1; on rsp_valid & rsp_ready go to IDLE next cycle.
REQ-024 SHALL keep result holding the last completed matrix while in IDLE until the next acceptance.
REQ-025 SHALL not accept a new command in the same cycle a response is consumed (minimum one IDLE cycle between commands).

Reset
REQ-026 SHALL on reset assertion immediately force state IDLE, row counter 0, captured operands 0, result 0, rsp_valid 0, rsp_error 0, busy 0, cmd_ready 1.
REQ-027 SHALL on reset during RUN or DONE abort the operation with no response produced.

Structure
REQ-028 SHALL take ELEM_W and N_DIM defaults, the opcode encodings (OP_ADD, OP_SUB, OP_NEG, OP_RSVD) and the state encoding from shared package mpu_pkg.
REQ-029 SHALL instantiate one combinational sub-module mpu_row_alu (N_DIM lanes, inputs: two rows and op; output: one row).

Verification
REQ-030 SHALL cover SUB: A element e = e+1, B element e = 25-e -> after 5 cycles rsp_valid=1, result e0=232, e12=0, e24=24, rsp_error=0.
REQ-031 SHALL cover ADD on the same operands -> every element = 26; NEG with A e0=1 -> result e0=255, B ignored.
REQ-032 SHALL cover backpressure: rsp_ready low 3 cycles in DONE -> result and rsp_valid stable, cmd_ready=0; IDLE one cycle after rsp_ready=1.
REQ-033 SHALL cover opcode 11 -> rsp_valid one cycle after acceptance, rsp_error=1, result all zeros.
REQ-034 SHALL cover operand change after acceptance (matrix_a driven to all 8'hFF) -> result matches originally captured operands.
REQ-035 SHALL cover reset asserted in RUN at row 2 -> all outputs at reset values immediately, no rsp_valid afterwards, next command completes normally.
